instr_fetch: RTL

Instruction fetch unit: the initiator on the instruction-ROM read port. Owns the program counter, drives a 7-bit word address and read enable into the 128×32 combinational-read instruction ROM, and captures the returned word into a 2-entry prefetch FIFO. Presents fetched instructions to decode over a valid/ready handshake and accepts branch redirects from execute.

---
 rtl/instr_fetch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. Owns the program counter, reads the combinational
// instruction ROM one word per cycle and queues each fetched word, together
// with its word address, in a small prefetch FIFO that feeds decode over a
// valid/ready handshake. A redirect from execute reloads the PC and flushes
// every queued (now stale) instruction.
//
// Parameters
//   ADDR_W    ROM word-address width; the PC counts words.
//   DATA_W    instruction width.
//   DEPTH     prefetch FIFO entries, 2 or 4 (pointers wrap as powers of two).
//   RESET_PC  PC value loaded on reset.
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset
//   rom_addr        out  ROM word address (always the current PC)
//   rom_en          out  ROM read enable, high only when the word is captured
//   rom_data        in   ROM read data, valid in the same cycle as rom_addr
//   redirect_valid  in   one-cycle branch/jump redirect request
//   redirect_pc     in   redirect target word address
//   inst_valid      out  FIFO head holds a valid instruction
//   inst_ready      in   decode accepts the head this cycle
//   inst_data       out  FIFO head instruction (0 when empty)
//   inst_pc         out  word address of inst_data (0 when empty)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int          ADDR_W   = 7,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  // FIFO storage: one {pc, data} pair per entry
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic valid_s;
  logic full_s;
  logic pop_s;
  logic push_s;

  // Handshake and fetch-enable decode
  always_comb begin
    valid_s = (count_q != {CNT_W{1'b0}});
    full_s  = (count_q == CNT_FULL);
    pop_s   = valid_s & inst_ready;
    // A full FIFO still accepts a word when its head leaves in the same cycle.
    // rst gates the enable so the ROM sees no read while reset is held.
    push_s  = ~rst & ~redirect_valid & (~full_s | pop_s);
  end

  // Next-state logic for PC, pointers and occupancy
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      // Flush wins over any concurrent pop; the popped entry is discarded.
      pc_d     = redirect_pc;
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        pc_d     = pc_q + PC_ONE;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // PC, pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC_C;
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write port: captures {pc, rom_data} on every accepted fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= {ADDR_W{1'b0}};
        data_mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      data_mem_q[wr_ptr_q] <= rom_data;
    end
  end

  // Output drive: the head is always a registered entry, never ROM bypass,
  // and reads as zero when the FIFO is empty.
  always_comb begin
    rom_addr   = pc_q;
    rom_en     = push_s;
    inst_valid = valid_s;
    if (valid_s) begin
      inst_data = data_mem_q[rd_ptr_q];
      inst_pc   = pc_mem_q[rd_ptr_q];
    end else begin
      inst_data = {DATA_W{1'b0}};
      inst_pc   = {ADDR_W{1'b0}};
    end
  end

endmodule
